// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage buffers.
// Holds default payload/exception widths, the exception-cause bit indices
// and the occupancy-counter width helper.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned EXCP_W_DEF = 10;

    // Exception-cause bit positions within the excp vector
    localparam int unsigned EXCP_PC_MISALIGN  = 0;
    localparam int unsigned EXCP_IF_BUS_ERR   = 1;
    localparam int unsigned EXCP_ILEGL_INSTR  = 2;
    localparam int unsigned EXCP_ECALL        = 3;
    localparam int unsigned EXCP_EBREAK       = 4;
    localparam int unsigned EXCP_MRET         = 5;
    localparam int unsigned EXCP_LD_MISALIGN  = 6;
    localparam int unsigned EXCP_LD_BUS_ERR   = 7;
    localparam int unsigned EXCP_ST_MISALIGN  = 8;
    localparam int unsigned EXCP_ST_BUS_ERR   = 9;

    // Bits needed to hold an occupancy of 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// DEPTH x WIDTH storage for the stage buffer.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Storage is intentionally not reset.
module pipe_fifo_mem #(
    parameter int unsigned WIDTH = 74,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with real backpressure, flush and exception halt.
// Ports: clk, rst_n (async active-low), flush_i;
//        in_valid_i/in_ready_o/in_data_i/in_excp_i upstream handshake;
//        out_valid_o/out_ready_i/out_data_o/out_excp_o/out_excp_any_o downstream;
//        count_o occupancy, halted_o intake stopped by an accepted exception.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned EXCP_W       = EXCP_W_DEF,
    parameter int unsigned DEPTH        = 2,
    parameter bit          ZERO_INVALID = 1'b1,
    parameter bit          HALT_ON_EXCP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_data_i,
    input  logic [EXCP_W-1:0]         in_excp_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [EXCP_W-1:0]         out_excp_o,
    output logic                      out_excp_any_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      halted_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned ENT_W = DATA_W + EXCP_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             halt;
    logic             push_c;
    logic             pop_c;
    logic [ENT_W-1:0] head;
    logic [DATA_W-1:0] head_data;
    logic [EXCP_W-1:0] head_excp;

    // Handshake: ready derives from registered state only, so a pop at full
    // never opens intake in the same cycle
    assign in_ready_o  = (count < CNT_W'(DEPTH)) & ~halt;
    assign out_valid_o = (count != '0);
    assign push_c      = in_valid_i & in_ready_o & ~flush_i;
    assign pop_c       = out_valid_o & out_ready_i & ~flush_i;

    // Pointers, occupancy and halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halt   <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halt   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Once an excepting entry is in, younger items must stay out
            halt <= HALT_ON_EXCP & (halt | (push_c & (|in_excp_i)));
        end
    end

    pipe_fifo_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr),
        .wdata ({in_data_i, in_excp_i}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_data = head[ENT_W-1:EXCP_W];
    assign head_excp = head[EXCP_W-1:0];

    // Optional masking of the head entry while nothing is valid
    assign out_data_o     = (ZERO_INVALID && !out_valid_o) ? '0 : head_data;
    assign out_excp_o     = (ZERO_INVALID && !out_valid_o) ? '0 : head_excp;
    assign out_excp_any_o = out_valid_o & (|head_excp);

    assign count_o  = count;
    assign halted_o = halt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 instance driven from a vector
// table, a DEPTH=4 instance streamed against a queue model, plus an
// asynchronous reset sequence.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DEPTH=2 instance signals
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [9:0]  a_in_excp, a_out_excp;
    logic        a_excp_any, a_halted;
    logic [1:0]  a_count;

    // DEPTH=4 instance signals
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [9:0]  b_in_excp, b_out_excp;
    logic        b_excp_any, b_halted;
    logic [2:0]  b_count;

    pipe_stage_buf #(.DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_data_i(a_in_data), .in_excp_i(a_in_excp),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_data_o(a_out_data), .out_excp_o(a_out_excp),
        .out_excp_any_o(a_excp_any), .count_o(a_count), .halted_o(a_halted)
    );

    pipe_stage_buf #(.DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_data_i(b_in_data), .in_excp_i(b_in_excp),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_data_o(b_out_data), .out_excp_o(b_out_excp),
        .out_excp_any_o(b_excp_any), .count_o(b_count), .halted_o(b_halted)
    );

    typedef struct {
        logic        flush;
        logic        iv;
        logic [63:0] d;
        logic [9:0]  e;
        logic        ordy;
        logic        ev;
        logic [63:0] ed;
        logic [9:0]  ee;
        logic [1:0]  ec;
        logic        erdy;
        logic        ehalt;
        logic        eany;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic flush, input logic iv, input logic [63:0] d,
                                input logic [9:0] e, input logic ordy,
                                input logic ev, input logic [63:0] ed, input logic [9:0] ee,
                                input logic [1:0] ec, input logic erdy,
                                input logic ehalt, input logic eany);
        vec_t v;
        v.flush = flush; v.iv = iv; v.d = d; v.e = e; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ec = ec; v.erdy = erdy;
        v.ehalt = ehalt; v.eany = eany;
        return v;
    endfunction

    initial begin
        int sent;
        int got;
        int mcount;
        logic [63:0] q[$];
        logic m_push;
        logic m_pop;

        // Expected state after the clock edge at which each row is applied
        //             fl iv data   excp    ordy  ev  edata  eexcp   cnt rdy hlt any
        vecs[0]  = mk(0, 1, 'hA1, 10'h000, 1,   1, 'hA1, 10'h000, 1, 1, 0, 0);
        vecs[1]  = mk(0, 1, 'hA2, 10'h000, 1,   1, 'hA2, 10'h000, 1, 1, 0, 0);
        vecs[2]  = mk(0, 1, 'hA3, 10'h000, 1,   1, 'hA3, 10'h000, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 'h00, 10'h000, 1,   0, 'h00, 10'h000, 0, 1, 0, 0);
        vecs[4]  = mk(0, 1, 'h11, 10'h000, 0,   1, 'h11, 10'h000, 1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 'h22, 10'h000, 0,   1, 'h11, 10'h000, 2, 0, 0, 0);
        vecs[6]  = mk(0, 1, 'h33, 10'h000, 0,   1, 'h11, 10'h000, 2, 0, 0, 0);
        vecs[7]  = mk(0, 1, 'h33, 10'h000, 1,   1, 'h22, 10'h000, 1, 1, 0, 0);
        vecs[8]  = mk(0, 1, 'h33, 10'h000, 1,   1, 'h33, 10'h000, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 'h00, 10'h000, 1,   0, 'h00, 10'h000, 0, 1, 0, 0);
        vecs[10] = mk(0, 1, 'h55, 10'h008, 0,   1, 'h55, 10'h008, 1, 0, 1, 1);
        vecs[11] = mk(0, 1, 'h66, 10'h000, 0,   1, 'h55, 10'h008, 1, 0, 1, 1);
        vecs[12] = mk(0, 1, 'h66, 10'h000, 1,   0, 'h00, 10'h000, 0, 0, 1, 0);
        vecs[13] = mk(1, 0, 'h00, 10'h000, 0,   0, 'h00, 10'h000, 0, 1, 0, 0);
        vecs[14] = mk(0, 1, 'h77, 10'h000, 0,   1, 'h77, 10'h000, 1, 1, 0, 0);
        vecs[15] = mk(0, 1, 'h88, 10'h000, 0,   1, 'h77, 10'h000, 2, 0, 0, 0);
        vecs[16] = mk(1, 1, 'h99, 10'h000, 0,   0, 'h00, 10'h000, 0, 1, 0, 0);
        vecs[17] = mk(0, 0, 'h00, 10'h000, 1,   0, 'h00, 10'h000, 0, 1, 0, 0);
        vecs[18] = mk(0, 1, 'hAB, 10'h000, 0,   1, 'hAB, 10'h000, 1, 1, 0, 0);
        vecs[19] = mk(0, 1, 'hCD, 10'h000, 0,   1, 'hAB, 10'h000, 2, 0, 0, 0);

        rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_excp = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_excp = '0; b_out_ready = 0;

        // Reset state
        #12;
        chk("rst_valid",  64'(a_out_valid), 64'(0));
        chk("rst_count",  64'(a_count),     64'(0));
        chk("rst_ready",  64'(a_in_ready),  64'(1));
        chk("rst_halted", 64'(a_halted),    64'(0));
        chk("rst_data",   a_out_data,       64'(0));
        chk("rst_excp",   64'(a_out_excp),  64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors on the DEPTH=2 instance
        for (int i = 0; i < NVEC; i++) begin
            a_flush     = vecs[i].flush;
            a_in_valid  = vecs[i].iv;
            a_in_data   = vecs[i].d;
            a_in_excp   = vecs[i].e;
            a_out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i),  64'(a_out_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d_data", i),   a_out_data,       vecs[i].ed);
            chk($sformatf("v%0d_excp", i),   64'(a_out_excp),  64'(vecs[i].ee));
            chk($sformatf("v%0d_count", i),  64'(a_count),     64'(vecs[i].ec));
            chk($sformatf("v%0d_ready", i),  64'(a_in_ready),  64'(vecs[i].erdy));
            chk($sformatf("v%0d_halted", i), 64'(a_halted),    64'(vecs[i].ehalt));
            chk($sformatf("v%0d_any", i),    64'(a_excp_any),  64'(vecs[i].eany));
        end
        a_flush = 0; a_in_valid = 0; a_out_ready = 0;

        // Pointer wrap on the DEPTH=4 instance against a queue model
        sent = 1;
        got = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            b_in_valid  = (sent <= 10);
            b_in_data   = 64'(sent);
            b_out_ready = 1'($urandom_range(0, 1));
            chk("wrap_count", 64'(b_count),    64'(mcount));
            chk("wrap_ready", 64'(b_in_ready), 64'(mcount < 4));
            chk("wrap_valid", 64'(b_out_valid), 64'(mcount != 0));
            if (mcount != 0) begin
                chk("wrap_data", b_out_data, q[0]);
            end
            m_push = b_in_valid && (mcount < 4);
            m_pop  = (mcount != 0) && b_out_ready;
            if (m_pop) begin
                void'(q.pop_front());
                got++;
                mcount--;
            end
            if (m_push) begin
                q.push_back(64'(sent));
                sent++;
                mcount++;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 0;
        b_out_ready = 0;
        chk("wrap_done",  64'(got),     64'(10));
        chk("wrap_final", 64'(b_count), 64'(0));

        // Asynchronous reset between clock edges with two entries queued
        chk("pre_arst_count", 64'(a_count), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(a_out_valid), 64'(0));
        chk("arst_count", 64'(a_count),     64'(0));
        chk("arst_ready", 64'(a_in_ready),  64'(1));
        chk("arst_data",  a_out_data,       64'(0));
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_arst_valid", 64'(a_out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
